color_identify_multi: RTL and testbench
=======================================

Name: color_identify_multi

Overview:
Pipelined RGB565 pixel classifier, the parametrised successor of the single-colour identifier. Converts each RGB565 pixel to 8-bit YCbCr. Tests the pixel against NUM_CLASS programmable colour windows and counts matches per class over a frame. Sits between the camera capture stage and the target-tracking logic, and reports per-frame counts plus the dominant colour class.

Parameters:
NUM_CLASS, 4, number of colour classes (1..8)
CNT_W, 20, width of each per-class frame counter (saturating)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_vsync  in  1  frame sync, high during vertical blanking
in_de  in  1  pixel valid
in_data  in  16  RGB565 pixel {R5,G6,B5}
cfg_we  in  1  threshold write strobe
cfg_addr  in  6  {class[2:0], field[2:0]}
cfg_wdata  in  8  threshold value
out_vsync  out  1  in_vsync delayed 4 cycles
out_de  out  1  in_de delayed 4 cycles
out_y  out  8  luma
out_cb  out  8  blue-difference chroma
out_cr  out  8  red-difference chroma
out_match  out  NUM_CLASS  per-class match flags, qualified by out_de
res_valid  out  1  1-cycle pulse: frame results updated
res_cnt  out  NUM_CLASS*CNT_W  per-class match counts of last frame, class k at [k*CNT_W +: CNT_W]
res_dom  out  3  index of class with largest count
res_dom_valid  out  1  1 when any count of last frame is nonzero

Behaviour:
- Reset (async, rst_n=0): every pipeline register, out_* signal, counter, res_* signal and res_valid is 0. Active and shadow thresholds reset to Y_min=0, Cb_lo=255, Cb_hi=0, Cr_lo=255, Cr_hi=0, so no class matches.
- Expansion: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- Conversion: Y=(77R+150G+29B)>>8. Cb=(-43R-85G+128B+32768)>>8. Cr=(128R-107G-21B+32768)>>8. Use 17-bit signed intermediates. The result is always within 0..255; no clamping is required.
- Pipeline with fixed latency 4, all outputs aligned:
  - S1 registers the expanded RGB888.
  - S2 registers the nine products.
  - S3 registers Y/Cb/Cr.
  - S4 registers the compares and the Y/Cb/Cr copies.
  - in_vsync and in_de travel alongside the data. The pipeline runs every cycle with no stall.
- Match for class k: Y>=Y_min[k] AND Cb_lo[k]<=Cb<=Cb_hi[k] AND Cr_lo[k]<=Cr<=Cr_hi[k]. Bounds are inclusive. out_match is forced to 0 when the S4 de is 0.
- Config fields: 0=Y_min, 1=Cb_lo, 2=Cb_hi, 3=Cr_lo, 4=Cr_hi.
  - cfg_we writes the shadow register the next edge.
  - A write to field 5..7 or to class>=NUM_CLASS is ignored.
- Frame event: the first cycle where out_vsync=1 and the registered previous out_vsync=0. A frame event does the following at the clock edge of that cycle:
  - The active thresholds load from the shadow. A cfg write on the same cycle lands in the shadow only and takes effect at the next event.
  - res_cnt loads the counters. An out_de match on the event cycle counts into the ending frame.
  - res_dom loads the index of the maximum count; ties go to the lowest index.
  - res_dom_valid = (max count != 0). If every count is zero, res_dom is 0.
  - The counters clear to 0.
  - res_valid is 1 for exactly the following cycle.
- Counters: counter k increments when out_de and out_match[k] are both 1, and saturates at 2^CNT_W-1.
- The first frame event after reset reports whatever partial frame was seen before it. Consumers discard it.
- Reset mid-frame clears everything immediately. The pipeline refills in 4 cycles after release.

Test Plan:
1. Conversion: config class0 = Y_min 190, Cb 0..40, Cr 130..140. Then drive in_de=1, in_data=16'b11001_110111_00011 for 1 cycle. Required: 4 cycles later out_de=1, out_y=195, out_cb=31, out_cr=135, out_match[0]=1, other match bits 0.
2. Window edges: with class0 windows set to exactly Y=195, Cb=31, Cr=135, the same pixel matches. Changing Cb_lo to 32 gives no match. Pixel 16'h0000 gives Y=0, Cb=128, Cr=128.
3. Frame counting: frame 1 has 100 matching pixels for class1 and 37 for class2, followed by an in_vsync rise. Required: res_valid pulses once; res_cnt class1=100, class2=37, others 0; res_dom=1; res_dom_valid=1. A second frame with no matches gives all counts 0, res_dom_valid=0, res_dom=0.
4. Config shadowing: rewrite class0 Cb_hi=0 mid-frame. Required: matches continue until the next frame event and stop in the frame after it. A write to addr {3'd0,3'd6} has no effect.
5. Saturation and ties: with CNT_W=4, drive 20 matches for class0 and 20 for class3. Required: both counts report 15 and res_dom=0.
6. Reset mid-frame: assert rst_n=0 during streaming. Required: outputs and counters are 0 immediately. The next frame event reports only pixels seen after release, and the thresholds are back to their no-match defaults.

Source files
------------

// File: rtl/color_identify_multi.sv
// color_identify_multi
// Pipelined RGB565 classifier. Each pixel is expanded to RGB888 and converted
// to 8-bit YCbCr, then tested against NUM_CLASS programmable colour windows.
// Matches are counted per class over a frame. Per-class counts and the index
// of the dominant class are reported at every rising edge of out_vsync.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_vsync/in_de        frame sync (high in blanking) / pixel valid
//   in_data               RGB565 pixel {R5,G6,B5}
//   cfg_we/addr/wdata     shadow threshold write; addr = {class[2:0], field[2:0]}
//                         field 0=Y_min 1=Cb_lo 2=Cb_hi 3=Cr_lo 4=Cr_hi
//   out_vsync/out_de      sync and valid delayed by 4 cycles
//   out_y/out_cb/out_cr   converted pixel, aligned with out_de
//   out_match             per-class match flags, zero when out_de is low
//   res_valid             one-cycle pulse after a frame event
//   res_cnt               last-frame counts, class k at [k*CNT_W +: CNT_W]
//   res_dom/res_dom_valid index of the largest count (ties -> lowest), any nonzero
module color_identify_multi #(
  parameter int NUM_CLASS = 4,
  parameter int CNT_W     = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_vsync,
  input  logic                       in_de,
  input  logic [15:0]                in_data,
  input  logic                       cfg_we,
  input  logic [5:0]                 cfg_addr,
  input  logic [7:0]                 cfg_wdata,
  output logic                       out_vsync,
  output logic                       out_de,
  output logic [7:0]                 out_y,
  output logic [7:0]                 out_cb,
  output logic [7:0]                 out_cr,
  output logic [NUM_CLASS-1:0]       out_match,
  output logic                       res_valid,
  output logic [NUM_CLASS*CNT_W-1:0] res_cnt,
  output logic [2:0]                 res_dom,
  output logic                       res_dom_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Accumulators hold byte.fraction in [15:0]; the result is the upper byte.
  function automatic logic [7:0] ycc_byte(input logic signed [16:0] acc);
    ycc_byte = 8'(acc >>> 8);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic hit);
    sat_inc = (hit && (c != CNT_MAX)) ? c + 1'b1 : c;
  endfunction

  function automatic logic signed [16:0] to_s17(input logic [7:0] v);
    to_s17 = $signed({9'd0, v});
  endfunction

  // Stage 1: expand RGB565 to RGB888 by replicating the top bits
  logic [7:0] r_p1, g_p1, b_p1;
  logic       vld_p1, vs_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1 <= '0; g_p1 <= '0; b_p1 <= '0; vld_p1 <= 1'b0; vs_p1 <= 1'b0;
    end else begin
      r_p1   <= {in_data[15:11], in_data[15:13]};
      g_p1   <= {in_data[10:5],  in_data[10:9]};
      b_p1   <= {in_data[4:0],   in_data[4:2]};
      vld_p1 <= in_de;
      vs_p1  <= in_vsync;
    end
  end

  // Stage 2: nine coefficient products, all stored as positive magnitudes
  logic signed [16:0] yr_p2, yg_p2, yb_p2, cbr_p2, cbg_p2, cbb_p2, crr_p2, crg_p2, crb_p2;
  logic               vld_p2, vs_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yr_p2 <= '0; yg_p2 <= '0; yb_p2 <= '0;
      cbr_p2 <= '0; cbg_p2 <= '0; cbb_p2 <= '0;
      crr_p2 <= '0; crg_p2 <= '0; crb_p2 <= '0;
      vld_p2 <= 1'b0; vs_p2 <= 1'b0;
    end else begin
      yr_p2  <= to_s17(r_p1) * 17'sd77;
      yg_p2  <= to_s17(g_p1) * 17'sd150;
      yb_p2  <= to_s17(b_p1) * 17'sd29;
      cbr_p2 <= to_s17(r_p1) * 17'sd43;
      cbg_p2 <= to_s17(g_p1) * 17'sd85;
      cbb_p2 <= to_s17(b_p1) * 17'sd128;
      crr_p2 <= to_s17(r_p1) * 17'sd128;
      crg_p2 <= to_s17(g_p1) * 17'sd107;
      crb_p2 <= to_s17(b_p1) * 17'sd21;
      vld_p2 <= vld_p1;
      vs_p2  <= vs_p1;
    end
  end

  // Stage 3: sums with +128 chroma offset. Final sums lie in 0..65535, so the
  // modulo-2^17 intermediate arithmetic yields the exact upper byte.
  logic [7:0] y_p3, cb_p3, cr_p3;
  logic       vld_p3, vs_p3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p3 <= '0; cb_p3 <= '0; cr_p3 <= '0; vld_p3 <= 1'b0; vs_p3 <= 1'b0;
    end else begin
      y_p3   <= ycc_byte(yr_p2 + yg_p2 + yb_p2);
      cb_p3  <= ycc_byte(17'sd32768 - cbr_p2 - cbg_p2 + cbb_p2);
      cr_p3  <= ycc_byte(17'sd32768 + crr_p2 - crg_p2 - crb_p2);
      vld_p3 <= vld_p2;
      vs_p3  <= vs_p2;
    end
  end

  // Threshold registers: shadow written by cfg, active loaded at frame events
  logic [7:0] ymin_sh [NUM_CLASS];
  logic [7:0] cblo_sh [NUM_CLASS];
  logic [7:0] cbhi_sh [NUM_CLASS];
  logic [7:0] crlo_sh [NUM_CLASS];
  logic [7:0] crhi_sh [NUM_CLASS];
  logic [7:0] ymin_act [NUM_CLASS];
  logic [7:0] cblo_act [NUM_CLASS];
  logic [7:0] cbhi_act [NUM_CLASS];
  logic [7:0] crlo_act [NUM_CLASS];
  logic [7:0] crhi_act [NUM_CLASS];

  // Writes to a class index with no instance never match any k and drop out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CLASS; k++) begin
        ymin_sh[k] <= 8'd0;   cblo_sh[k] <= 8'd255; cbhi_sh[k] <= 8'd0;
        crlo_sh[k] <= 8'd255; crhi_sh[k] <= 8'd0;
      end
    end else begin
      for (int k = 0; k < NUM_CLASS; k++) begin
        if (cfg_we && (cfg_addr[5:3] == 3'(k))) begin
          case (cfg_addr[2:0])
            3'd0:    ymin_sh[k] <= cfg_wdata;
            3'd1:    cblo_sh[k] <= cfg_wdata;
            3'd2:    cbhi_sh[k] <= cfg_wdata;
            3'd3:    crlo_sh[k] <= cfg_wdata;
            3'd4:    crhi_sh[k] <= cfg_wdata;
            default: ;
          endcase
        end
      end
    end
  end

  logic [NUM_CLASS-1:0] hit_p3;

  always_comb begin
    hit_p3 = '0;
    for (int k = 0; k < NUM_CLASS; k++) begin
      hit_p3[k] = vld_p3 && (y_p3 >= ymin_act[k]) &&
                  (cb_p3 >= cblo_act[k]) && (cb_p3 <= cbhi_act[k]) &&
                  (cr_p3 >= crlo_act[k]) && (cr_p3 <= crhi_act[k]);
    end
  end

  // Stage 4: registered compares and YCbCr copies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_y <= '0; out_cb <= '0; out_cr <= '0; out_match <= '0;
      out_de <= 1'b0; out_vsync <= 1'b0;
    end else begin
      out_y     <= y_p3;
      out_cb    <= cb_p3;
      out_cr    <= cr_p3;
      out_match <= hit_p3;
      out_de    <= vld_p3;
      out_vsync <= vs_p3;
    end
  end

  // Frame statistics: the event cycle's own match is folded in via cnt_nxt.
  logic                 vs_prev;
  logic                 frame_evt;
  logic [CNT_W-1:0]     cnt     [NUM_CLASS];
  logic [CNT_W-1:0]     cnt_nxt [NUM_CLASS];
  logic [CNT_W-1:0]     max_v;
  logic [2:0]           dom_idx;

  assign frame_evt = out_vsync & ~vs_prev;

  always_comb begin
    for (int k = 0; k < NUM_CLASS; k++) begin
      cnt_nxt[k] = sat_inc(cnt[k], out_de & out_match[k]);
    end
    max_v   = cnt_nxt[0];
    dom_idx = 3'd0;
    // Strict compare keeps the lowest index on ties.
    for (int k = 1; k < NUM_CLASS; k++) begin
      if (cnt_nxt[k] > max_v) begin
        max_v   = cnt_nxt[k];
        dom_idx = 3'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev <= 1'b0; res_valid <= 1'b0; res_cnt <= '0;
      res_dom <= '0; res_dom_valid <= 1'b0;
      for (int k = 0; k < NUM_CLASS; k++) begin
        cnt[k]      <= '0;
        ymin_act[k] <= 8'd0;   cblo_act[k] <= 8'd255; cbhi_act[k] <= 8'd0;
        crlo_act[k] <= 8'd255; crhi_act[k] <= 8'd0;
      end
    end else begin
      vs_prev   <= out_vsync;
      res_valid <= frame_evt;
      if (frame_evt) begin
        res_dom       <= dom_idx;
        res_dom_valid <= (max_v != '0);
        for (int k = 0; k < NUM_CLASS; k++) begin
          res_cnt[k*CNT_W +: CNT_W] <= cnt_nxt[k];
          cnt[k]      <= '0;
          ymin_act[k] <= ymin_sh[k];
          cblo_act[k] <= cblo_sh[k];
          cbhi_act[k] <= cbhi_sh[k];
          crlo_act[k] <= crlo_sh[k];
          crhi_act[k] <= crhi_sh[k];
        end
      end else begin
        for (int k = 0; k < NUM_CLASS; k++) cnt[k] <= cnt_nxt[k];
      end
    end
  end

endmodule

// File: tb/tb_color_identify_multi.sv
module tb_color_identify_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vsync, in_de;
  logic [15:0] in_data;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [7:0]  cfg_wdata;

  logic        out_vsync, out_de, res_valid, res_dom_valid;
  logic [7:0]  out_y, out_cb, out_cr;
  logic [3:0]  out_match;
  logic [79:0] res_cnt;
  logic [2:0]  res_dom;

  logic        out_vsync2, out_de2, res_valid2, res_dom_valid2;
  logic [7:0]  out_y2, out_cb2, out_cr2;
  logic [3:0]  out_match2;
  logic [15:0] res_cnt2;
  logic [2:0]  res_dom2;

  int checks = 0;
  int failures = 0;

  localparam logic [15:0] PIX_A = 16'b11001_110111_00011; // Y195 Cb31 Cr135
  localparam logic [15:0] PIX_0 = 16'h0000;               // Y0 Cb128 Cr128

  color_identify_multi #(.NUM_CLASS(4), .CNT_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .in_vsync(in_vsync), .in_de(in_de), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .out_vsync(out_vsync), .out_de(out_de), .out_y(out_y), .out_cb(out_cb), .out_cr(out_cr),
    .out_match(out_match), .res_valid(res_valid), .res_cnt(res_cnt), .res_dom(res_dom),
    .res_dom_valid(res_dom_valid));

  color_identify_multi #(.NUM_CLASS(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_vsync(in_vsync), .in_de(in_de), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .out_vsync(out_vsync2), .out_de(out_de2), .out_y(out_y2), .out_cb(out_cb2), .out_cr(out_cr2),
    .out_match(out_match2), .res_valid(res_valid2), .res_cnt(res_cnt2), .res_dom(res_dom2),
    .res_dom_valid(res_dom_valid2));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [2:0] cls, input logic [2:0] fld, input logic [7:0] val);
    cfg_we = 1'b1; cfg_addr = {cls, fld}; cfg_wdata = val;
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic cfg_win(input logic [2:0] cls, input logic [7:0] ymin, input logic [7:0] cblo,
                         input logic [7:0] cbhi, input logic [7:0] crlo, input logic [7:0] crhi);
    cfg(cls, 3'd0, ymin); cfg(cls, 3'd1, cblo); cfg(cls, 3'd2, cbhi);
    cfg(cls, 3'd3, crlo); cfg(cls, 3'd4, crhi);
  endtask

  // Returns just after the edge at which res_valid rises.
  task automatic frame();
    in_vsync = 1'b1;
    step(1);
    in_vsync = 1'b0;
    step(4);
  endtask

  task automatic pixels(input logic [15:0] px, input int n);
    in_de = 1'b1; in_data = px;
    step(n);
    in_de = 1'b0;
  endtask

  function automatic logic [63:0] cnt_of(input int k);
    return 64'(res_cnt[k*20 +: 20]);
  endfunction

  function automatic logic [63:0] cnt2_of(input int k);
    return 64'(res_cnt2[k*4 +: 4]);
  endfunction

  initial begin
    rst_n = 1'b0; in_vsync = 1'b0; in_de = 1'b0; in_data = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    step(2);
    chk("rst_out_de", 64'(out_de), 64'd0);
    chk("rst_out_y", 64'(out_y), 64'd0);
    chk("rst_out_match", 64'(out_match), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_cnt_zero", 64'(res_cnt == '0), 64'd1);
    chk("rst_res_dom", 64'({res_dom, res_dom_valid}), 64'd0);
    rst_n = 1'b1;
    step(1);

    // Default thresholds: converts but matches nothing
    pixels(PIX_A, 1); step(3);
    chk("dflt_out_de", 64'(out_de), 64'd1);
    chk("dflt_out_y", 64'(out_y), 64'd195);
    chk("dflt_match", 64'(out_match), 64'd0);

    // Conversion and class0 match
    cfg_win(3'd0, 8'd190, 8'd0, 8'd40, 8'd130, 8'd140);
    frame();
    pixels(PIX_A, 1); step(3);
    chk("conv_de", 64'(out_de), 64'd1);
    chk("conv_y", 64'(out_y), 64'd195);
    chk("conv_cb", 64'(out_cb), 64'd31);
    chk("conv_cr", 64'(out_cr), 64'd135);
    chk("conv_match", 64'(out_match), 64'b0001);
    step(1);
    chk("conv_de_after", 64'(out_de), 64'd0);
    chk("conv_match_after", 64'(out_match), 64'd0);

    // Window edges
    cfg_win(3'd0, 8'd195, 8'd31, 8'd31, 8'd135, 8'd135);
    frame();
    pixels(PIX_A, 1); step(3);
    chk("edge_exact_match", 64'(out_match), 64'b0001);
    cfg(3'd0, 3'd1, 8'd32);
    frame();
    pixels(PIX_A, 1); step(3);
    chk("edge_cblo32_match", 64'(out_match), 64'd0);
    pixels(PIX_0, 1); step(3);
    chk("zero_y", 64'(out_y), 64'd0);
    chk("zero_cb", 64'(out_cb), 64'd128);
    chk("zero_cr", 64'(out_cr), 64'd128);
    chk("zero_match", 64'(out_match), 64'd0);

    // Frame counting; last class2 pixel coincides with the vsync rise
    cfg_win(3'd1, 8'd190, 8'd0, 8'd40, 8'd130, 8'd140);
    cfg_win(3'd2, 8'd0, 8'd128, 8'd128, 8'd128, 8'd128);
    frame();
    pixels(PIX_A, 100);
    pixels(PIX_0, 36);
    in_de = 1'b1; in_data = PIX_0; in_vsync = 1'b1;
    step(1);
    in_de = 1'b0; in_vsync = 1'b0;
    step(4);
    chk("f1_res_valid", 64'(res_valid), 64'd1);
    chk("f1_cnt0", cnt_of(0), 64'd0);
    chk("f1_cnt1", cnt_of(1), 64'd100);
    chk("f1_cnt2", cnt_of(2), 64'd37);
    chk("f1_cnt3", cnt_of(3), 64'd0);
    chk("f1_dom", 64'(res_dom), 64'd1);
    chk("f1_dom_valid", 64'(res_dom_valid), 64'd1);
    step(1);
    chk("f1_res_valid_pulse", 64'(res_valid), 64'd0);
    frame();
    chk("f2_res_valid", 64'(res_valid), 64'd1);
    chk("f2_cnt_zero", 64'(res_cnt == '0), 64'd1);
    chk("f2_dom", 64'(res_dom), 64'd0);
    chk("f2_dom_valid", 64'(res_dom_valid), 64'd0);

    // Saturation and ties
    cfg_win(3'd0, 8'd190, 8'd0, 8'd40, 8'd130, 8'd140);
    cfg_win(3'd3, 8'd190, 8'd0, 8'd40, 8'd130, 8'd140);
    cfg(3'd1, 3'd1, 8'd255);
    frame();
    pixels(PIX_A, 20);
    frame();
    chk("sat_cnt0", cnt2_of(0), 64'd15);
    chk("sat_cnt3", cnt2_of(3), 64'd15);
    chk("sat_dom", 64'(res_dom2), 64'd0);
    chk("tie_cnt0", cnt_of(0), 64'd20);
    chk("tie_cnt3", cnt_of(3), 64'd20);
    chk("tie_dom", 64'(res_dom), 64'd0);

    // Ignored writes and shadowing
    cfg(3'd4, 3'd1, 8'd255);
    cfg(3'd0, 3'd6, 8'd0);
    frame();
    pixels(PIX_A, 1); step(3);
    chk("ignored_wr_match", 64'(out_match), 64'b1001);
    pixels(PIX_A, 5);
    cfg(3'd0, 3'd2, 8'd0);
    pixels(PIX_A, 1); step(3);
    chk("shadow_still_match", 64'(out_match), 64'b1001);
    frame();
    chk("shadow_cnt0", cnt_of(0), 64'd7);
    chk("shadow_cnt3", cnt_of(3), 64'd7);
    pixels(PIX_A, 1); step(3);
    chk("shadow_applied_match", 64'(out_match), 64'b1000);

    // Reset mid-frame
    in_de = 1'b1; in_data = PIX_A;
    step(8);
    rst_n = 1'b0;
    #1;
    chk("mrst_out_de", 64'(out_de), 64'd0);
    chk("mrst_out_y", 64'(out_y), 64'd0);
    chk("mrst_match", 64'(out_match), 64'd0);
    chk("mrst_res_cnt_zero", 64'(res_cnt == '0), 64'd1);
    in_de = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    pixels(PIX_A, 1); step(3);
    chk("mrst_refill_de", 64'(out_de), 64'd1);
    chk("mrst_dflt_match", 64'(out_match), 64'd0);
    frame();
    chk("mrst_evt_valid", 64'(res_valid), 64'd1);
    chk("mrst_evt_cnt_zero", 64'(res_cnt == '0), 64'd1);
    chk("mrst_evt_dom_valid", 64'(res_dom_valid), 64'd0);
    cfg_win(3'd3, 8'd190, 8'd0, 8'd40, 8'd130, 8'd140);
    frame();
    pixels(PIX_A, 7);
    frame();
    chk("post_cnt3", cnt_of(3), 64'd7);
    chk("post_cnt0", cnt_of(0), 64'd0);
    chk("post_dom", 64'(res_dom), 64'd3);
    chk("post_dom_valid", 64'(res_dom_valid), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
